uart_tx_burst: RTL and testbench
================================

// Module: uart_tx_burst
// PURPOSE
//  Parametrised UART transmitter for multi-word payloads. Latches a
//  NUM_WORDS x DATA_BITS payload on a load strobe. Serialises each word as a
//  framed UART character: start, data LSB-first, optional even/odd parity,
//  1 or 2 stop bits. Bit timing comes from an internal CLK_DIV baud divider.
//  Sits between the acquisition/packing logic and the board TXD pin.
// PARAMETERS
//  CLK_DIV    434  clk cycles per UART bit (>=2); 434 = 115200 Bd at 50 MHz
//  DATA_BITS  8    bits per character (5..8)
//  NUM_WORDS  8    characters per burst (>=1)
//  STOP_BITS  1    stop bits per character (1 or 2)
// PORTS
//  clk          in   1                    system clock
//  rst_m        in   1                    asynchronous reset, active-high
//  load         in   1                    1-cycle strobe: latch data, start burst
//  data         in   NUM_WORDS*DATA_BITS  payload; word 0 = data[DATA_BITS-1:0]
//  parity_en    in   1                    1 = append parity bit
//  parity_kind  in   1                    0 = even, 1 = odd
//  txd_en       in   1                    0 = pause at next character boundary
//  txd          out  1                    serial line, idle high
//  busy         out  1                    burst in progress (load ignored)
//  done         out  1                    1-cycle pulse at end of burst
// BEHAVIOUR
//  Reset (async, rst_m=1): state IDLE, txd=1, busy=0, done=0, counters=0,
//   shift register=0. Reset mid-frame aborts immediately; txd high next edge.
//  load accepted only in IDLE. Latched in the same edge: data,
//   parity_en, parity_kind. Later changes do not affect the burst.
//  load while busy: ignored; no effect on the frame in flight.
//  Accepted load: busy=1 and txd=0 (start bit) from the next cycle.
//  Baud counter reloads at each bit start. Every bit lasts exactly
//   CLK_DIV cycles.
//  FSM: IDLE -> START -> DATA (DATA_BITS bits, LSB first)
//   -> PARITY (only if parity_en) -> STOP (STOP_BITS bit-times)
//   -> [word idx < NUM_WORDS-1] ? (txd_en ? START : HOLD) : IDLE.
//  HOLD: txd=1, busy=1. Leaves for START the cycle after txd_en is sampled 1.
//  txd_en is sampled only at the STOP-end boundary. Deasserting it
//   mid-character never truncates the character.
//  Gap between characters with txd_en=1 is zero: a new start bit directly
//   follows the last stop bit.
//  Parity: even -> bit = XOR(word); odd -> bit = ~XOR(word).
//  Character length = (1+DATA_BITS+parity_en+STOP_BITS)*CLK_DIV cycles.
//  Burst end: after the last stop bit of word NUM_WORDS-1, busy->0 and
//   done=1 for exactly one cycle. load is accepted in that same cycle.
//  Word index wraps to 0 on burst end. No partial-burst or restart mode.
//  txd is driven from a flop (glitch-free).
// TESTING (CLK_DIV=4, DATA_BITS=8, NUM_WORDS=2, STOP_BITS=1 unless noted)
//  1 Reset: assert rst_m mid-character -> txd=1, busy=0, done=0 within one
//    clk edge. After release, load with data=16'h00A5 -> first bit starts.
//  2 parity_en=0, data=16'h3C55 -> txd: 0,1010_1010,1 then 0,0011_1100,1;
//    4 cycles/bit; done pulses once, 80 cycles after load.
//  3 parity_en=1, kind=0, word 8'h07 -> parity bit 1.
//    kind=1 -> parity bit 0. Each character lasts 44 cycles.
//  4 txd_en=0 before first stop bit ends -> txd held 1, busy=1 for 20 cycles.
//    Raise txd_en -> second start bit on the following cycle.
//  5 load pulsed while busy with different data -> transmitted bits unchanged.
//    load on the done cycle -> new burst starts next cycle.
//  6 STOP_BITS=2, NUM_WORDS=1, DATA_BITS=7 -> stop high for 8 cycles.
//    Character lasts 40 cycles.

Source files
------------

// File: rtl/uart_tx_burst.sv
// Multi-word UART transmitter: latches a packed payload on load and sends each word
// as a framed character (start, LSB-first data, optional parity, stop) at CLK_DIV clocks per bit.
module uart_tx_burst #(
  parameter int CLK_DIV   = 434,
  parameter int DATA_BITS = 8,
  parameter int NUM_WORDS = 8,
  parameter int STOP_BITS = 1
) (
  input  logic                           clk,
  input  logic                           rst_m,
  input  logic                           load,
  input  logic [NUM_WORDS*DATA_BITS-1:0] data,
  input  logic                           parity_en,
  input  logic                           parity_kind,
  input  logic                           txd_en,
  output logic                           txd,
  output logic                           busy,
  output logic                           done
);

  localparam int PW = NUM_WORDS * DATA_BITS;
  localparam int CW = $clog2(CLK_DIV);
  localparam int WW = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;
  localparam int BW = 4;

  typedef enum logic [2:0] {
    S_IDLE, S_START, S_DATA, S_PARITY, S_STOP, S_HOLD
  } state_t;

  state_t                 state_q, state_d;
  logic [CW-1:0]          baud_q, baud_d;
  logic [BW-1:0]          bit_q, bit_d;
  logic [WW-1:0]          word_q, word_d;
  logic [DATA_BITS-1:0]   shreg_q, shreg_d;
  logic [PW-1:0]          buf_q, buf_d;
  logic                   par_q, par_d;
  logic                   pen_q, pen_d;
  logic                   pkind_q, pkind_d;
  logic                   txd_q, txd_d;
  logic                   done_q, done_d;
  logic                   bit_end;

  always_ff @(posedge clk or posedge rst_m) begin
    if (rst_m) begin
      state_q <= S_IDLE;
      baud_q  <= '0;
      bit_q   <= '0;
      word_q  <= '0;
      shreg_q <= '0;
      buf_q   <= '0;
      par_q   <= 1'b0;
      pen_q   <= 1'b0;
      pkind_q <= 1'b0;
      txd_q   <= 1'b1;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      baud_q  <= baud_d;
      bit_q   <= bit_d;
      word_q  <= word_d;
      shreg_q <= shreg_d;
      buf_q   <= buf_d;
      par_q   <= par_d;
      pen_q   <= pen_d;
      pkind_q <= pkind_d;
      txd_q   <= txd_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    baud_d  = baud_q;
    bit_d   = bit_q;
    word_d  = word_q;
    shreg_d = shreg_q;
    buf_d   = buf_q;
    par_d   = par_q;
    pen_d   = pen_q;
    pkind_d = pkind_q;
    bit_end = (baud_q == CW'(CLK_DIV - 1));
    // The baud counter restarts at every bit boundary, so each bit is exactly CLK_DIV clocks.
    if (state_q != S_IDLE && state_q != S_HOLD) begin
      baud_d = bit_end ? '0 : baud_q + 1'b1;
    end
    case (state_q)
      S_IDLE: begin
        if (load) begin
          state_d = S_START;
          baud_d  = '0;
          word_d  = '0;
          shreg_d = data[DATA_BITS-1:0];
          par_d   = ^data[DATA_BITS-1:0];
          buf_d   = data >> DATA_BITS;
          pen_d   = parity_en;
          pkind_d = parity_kind;
        end
      end
      S_START: begin
        if (bit_end) begin
          state_d = S_DATA;
          bit_d   = '0;
        end
      end
      S_DATA: begin
        if (bit_end) begin
          shreg_d = shreg_q >> 1;
          if (bit_q == BW'(DATA_BITS - 1)) begin
            state_d = pen_q ? S_PARITY : S_STOP;
            bit_d   = '0;
          end else begin
            bit_d = bit_q + 1'b1;
          end
        end
      end
      S_PARITY: begin
        if (bit_end) begin
          state_d = S_STOP;
          bit_d   = '0;
        end
      end
      S_STOP: begin
        if (bit_end) begin
          if (bit_q == BW'(STOP_BITS - 1)) begin
            bit_d = '0;
            if (word_q == WW'(NUM_WORDS - 1)) begin
              state_d = S_IDLE;
              word_d  = '0;
            end else begin
              // Next word is staged now so HOLD only has to wait for txd_en.
              state_d = txd_en ? S_START : S_HOLD;
              word_d  = word_q + 1'b1;
              shreg_d = buf_q[DATA_BITS-1:0];
              par_d   = ^buf_q[DATA_BITS-1:0];
              buf_d   = buf_q >> DATA_BITS;
            end
          end else begin
            bit_d = bit_q + 1'b1;
          end
        end
      end
      S_HOLD: begin
        if (txd_en) begin
          state_d = S_START;
          baud_d  = '0;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    busy   = (state_q != S_IDLE);
    txd    = txd_q;
    done   = done_q;
    done_d = (state_q == S_STOP) && (state_d == S_IDLE);
    case (state_d)
      S_START:  txd_d = 1'b0;
      S_DATA:   txd_d = shreg_d[0];
      S_PARITY: txd_d = par_q ^ pkind_q;
      default:  txd_d = 1'b1;
    endcase
  end

endmodule

// File: tb/tb_uart_tx_burst.sv
// Directed bench for uart_tx_burst: a 2-word/8-bit/1-stop instance and a
// 1-word/7-bit/2-stop instance, both at 4 clocks per bit.
module tb_uart_tx_burst;

  logic        clk = 1'b0;
  logic        rst_m = 1'b0;
  logic        load = 1'b0;
  logic [15:0] data = '0;
  logic        parity_en = 1'b0;
  logic        parity_kind = 1'b0;
  logic        txd_en = 1'b1;
  logic        txd, busy, done;

  logic        load6 = 1'b0;
  logic [6:0]  data6 = '0;
  logic        txd6, busy6, done6;

  int n_cmp = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  uart_tx_burst #(.CLK_DIV(4), .DATA_BITS(8), .NUM_WORDS(2), .STOP_BITS(1)) dut (
    .clk(clk), .rst_m(rst_m), .load(load), .data(data),
    .parity_en(parity_en), .parity_kind(parity_kind), .txd_en(txd_en),
    .txd(txd), .busy(busy), .done(done)
  );

  uart_tx_burst #(.CLK_DIV(4), .DATA_BITS(7), .NUM_WORDS(1), .STOP_BITS(2)) dut6 (
    .clk(clk), .rst_m(rst_m), .load(load6), .data(data6),
    .parity_en(1'b0), .parity_kind(1'b0), .txd_en(1'b1),
    .txd(txd6), .busy(busy6), .done(done6)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Bit i of 'bits' is the i-th transmitted bit; one sample per bit, mid-bit.
  task automatic expect_bits(input int sel, input logic [31:0] bits, input int n,
                             input int first, input string tag);
    for (int i = 0; i < n; i++) begin
      cyc((i == 0) ? first : 4);
      chk($sformatf("%s_bit%0d", tag, i), (sel != 0) ? txd6 : txd, bits[i]);
    end
  endtask

  initial begin
    // Test 1: reset state, reset mid-character, restart
    #2 rst_m = 1'b1;
    cyc(2);
    chk("rst_txd", txd, 1);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_txd6", txd6, 1);
    chk("rst_busy6", busy6, 0);
    rst_m = 1'b0;
    cyc(1);
    data = 16'h00A5; load = 1'b1;
    cyc(1);
    load = 1'b0;
    chk("t1_start", txd, 0);
    chk("t1_busy", busy, 1);
    cyc(4);
    chk("t1_d0", txd, 1);
    cyc(3);
    #2 rst_m = 1'b1;
    #1;
    chk("t1_abort_txd", txd, 1);
    chk("t1_abort_busy", busy, 0);
    chk("t1_abort_done", done, 0);
    cyc(1);
    rst_m = 1'b0;
    chk("t1_idle_txd", txd, 1);
    cyc(1);
    load = 1'b1;
    cyc(1);
    load = 1'b0;
    chk("t1_restart_start", txd, 0);
    chk("t1_restart_busy", busy, 1);
    cyc(3);
    chk("t1_start_len", txd, 0);
    cyc(1);
    chk("t1_restart_d0", txd, 1);
    #2 rst_m = 1'b1;
    cyc(1);
    rst_m = 1'b0;
    cyc(1);

    // Test 2: two words, no parity
    data = 16'h3C55; parity_en = 1'b0; load = 1'b1;
    cyc(1);
    load = 1'b0;
    expect_bits(0, 32'h9E2AA, 20, 2, "t2");
    cyc(1);
    chk("t2_done_early", done, 0);
    chk("t2_busy_early", busy, 1);
    cyc(1);
    chk("t2_done", done, 1);
    chk("t2_busy_end", busy, 0);
    chk("t2_txd_end", txd, 1);
    cyc(1);
    chk("t2_done_once", done, 0);

    // Test 3: even then odd parity
    data = 16'h0707; parity_en = 1'b1; parity_kind = 1'b0; load = 1'b1;
    cyc(1);
    load = 1'b0;
    expect_bits(0, 32'h30760E, 22, 2, "t3even");
    cyc(1);
    chk("t3even_done_early", done, 0);
    cyc(1);
    chk("t3even_done", done, 1);
    data = 16'h0007; parity_kind = 1'b1; load = 1'b1;
    cyc(1);
    load = 1'b0;
    expect_bits(0, 32'h30040E, 22, 2, "t3odd");
    cyc(1);
    chk("t3odd_done_early", done, 0);
    cyc(1);
    chk("t3odd_done", done, 1);
    cyc(1);

    // Test 4: pause between characters
    parity_en = 1'b0; parity_kind = 1'b0; txd_en = 1'b0;
    data = 16'h3C55; load = 1'b1;
    cyc(1);
    load = 1'b0;
    expect_bits(0, 32'h2AA, 10, 2, "t4c0");
    cyc(2);
    for (int k = 0; k < 20; k++) begin
      chk($sformatf("t4_hold_txd%0d", k), txd, 1);
      chk($sformatf("t4_hold_busy%0d", k), busy, 1);
      if (k < 19) cyc(1);
    end
    txd_en = 1'b1;
    cyc(1);
    chk("t4_resume_start", txd, 0);
    expect_bits(0, 32'h278, 10, 1, "t4c1");
    cyc(3);
    chk("t4_done", done, 1);
    chk("t4_busy_end", busy, 0);
    cyc(1);

    // Test 5: load while busy is ignored; load on the done cycle is accepted
    data = 16'h3C55; load = 1'b1;
    cyc(1);
    data = 16'h0000; parity_en = 1'b1; parity_kind = 1'b1;
    cyc(1);
    load = 1'b0;
    expect_bits(0, 32'h9E2AA, 20, 1, "t5");
    cyc(2);
    chk("t5_done", done, 1);
    load = 1'b1; data = 16'h00A5; parity_en = 1'b0; parity_kind = 1'b0;
    cyc(1);
    load = 1'b0;
    chk("t5_back2back_start", txd, 0);
    chk("t5_back2back_busy", busy, 1);
    chk("t5_back2back_done", done, 0);
    expect_bits(0, 32'h8034A, 20, 2, "t5b");
    cyc(2);
    chk("t5b_done", done, 1);
    cyc(1);

    // Test 6: 7 data bits, 2 stop bits, single word
    data6 = 7'h35; load6 = 1'b1;
    cyc(1);
    load6 = 1'b0;
    chk("t6_busy", busy6, 1);
    expect_bits(1, 32'h36A, 8, 2, "t6");
    cyc(1);
    chk("t6_last_data", txd6, 0);
    for (int k = 0; k < 8; k++) begin
      cyc(1);
      chk($sformatf("t6_stop%0d", k), txd6, 1);
    end
    cyc(1);
    chk("t6_done", done6, 1);
    chk("t6_busy_end", busy6, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
